// File: rtl/cpu_seq_pkg.sv
// Shared definitions for the instruction fetch sequencer: state encoding,
// opcode classes, the HALT opcode and load-destination select codes.
package cpu_seq_pkg;

    typedef enum logic [2:0] {
        FETCH   = 3'd0,
        DECODE  = 3'd1,
        OPERAND = 3'd2,
        EXECUTE = 3'd3,
        HALT    = 3'd4
    } seq_state_t;

    localparam logic [1:0] CLS_IMPLIED = 2'b00;
    localparam logic [1:0] CLS_LOAD    = 2'b01;
    localparam logic [1:0] CLS_JUMP    = 2'b10;
    localparam logic [1:0] CLS_SPECIAL = 2'b11;

    localparam logic [7:0] OPC_HALT = 8'hFF;

    localparam logic [1:0] DST_ACC   = 2'b00;
    localparam logic [1:0] DST_X     = 2'b01;
    localparam logic [1:0] DST_Y     = 2'b10;
    localparam logic [1:0] DST_FLAGS = 2'b11;

    function automatic logic [1:0] opc_class(input logic [7:0] opc);
        return opc[7:6];
    endfunction

    function automatic logic has_operand(input logic [7:0] opc);
        return (opc[7:6] == CLS_LOAD) || (opc[7:6] == CLS_JUMP);
    endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Multi-cycle instruction fetch/decode sequencer: fetches an opcode, optionally
// an operand byte, and issues single-cycle register-file strobes.
module fetch_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    output logic       mem_req,
    input  logic       mem_ack,
    input  logic [7:0] mem_rdata,
    output logic       ir_write,
    output logic       pc_inc,
    output logic       pc_write,
    output logic       acc_write,
    output logic       x_write,
    output logic       y_write,
    output logic       flags_write,
    output logic [7:0] operand,
    output logic       halted,
    output logic       bus_err
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

    seq_state_t       state;
    seq_state_t       state_nxt;
    logic [7:0]       opcode;
    logic [CNT_W-1:0] wait_cnt;
    logic             armed;
    logic             timeout;
    logic             stall;

    // armed holds off the very first request until one clock edge after reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= FETCH;
            armed    <= 1'b0;
            wait_cnt <= '0;
            bus_err  <= 1'b0;
            operand  <= 8'h00;
        end else begin
            state <= state_nxt;
            armed <= 1'b1;
            if (stall && !timeout)
                wait_cnt <= wait_cnt + CNT_W'(1);
            else
                wait_cnt <= '0;
            if (timeout)
                bus_err <= 1'b1;
            if (state == OPERAND && mem_ack)
                operand <= mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (ir_write)
            opcode <= mem_rdata;
    end

    always_comb begin
        state_nxt   = state;
        mem_req     = 1'b0;
        ir_write    = 1'b0;
        pc_inc      = 1'b0;
        pc_write    = 1'b0;
        acc_write   = 1'b0;
        x_write     = 1'b0;
        y_write     = 1'b0;
        flags_write = 1'b0;
        stall       = 1'b0;
        timeout     = 1'b0;

        case (state)
            FETCH: begin
                mem_req = run && armed;
                if (mem_req && mem_ack) begin
                    ir_write  = 1'b1;
                    pc_inc    = 1'b1;
                    state_nxt = DECODE;
                end
            end
            DECODE: begin
                if (opcode == OPC_HALT)
                    state_nxt = HALT;
                else if (has_operand(opcode))
                    state_nxt = OPERAND;
                else
                    state_nxt = FETCH;
            end
            OPERAND: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    pc_inc    = 1'b1;
                    state_nxt = EXECUTE;
                end
            end
            EXECUTE: begin
                if (opc_class(opcode) == CLS_LOAD) begin
                    case (opcode[1:0])
                        DST_ACC:   acc_write   = 1'b1;
                        DST_X:     x_write     = 1'b1;
                        DST_Y:     y_write     = 1'b1;
                        DST_FLAGS: flags_write = 1'b1;
                        default:   acc_write   = 1'b0;
                    endcase
                end else if (opc_class(opcode) == CLS_JUMP) begin
                    pc_write = 1'b1;
                end
                state_nxt = FETCH;
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: begin
                state_nxt = FETCH;
            end
        endcase

        // An unanswered request that exhausts its budget overrides the FSM.
        stall = mem_req && !mem_ack;
        if (stall && wait_cnt == WAIT_LAST) begin
            timeout   = 1'b1;
            state_nxt = HALT;
        end
    end

    assign halted = (state == HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a per-cycle vector table plus hand-written
// timeout, halt and asynchronous-reset sequences.
module tb_fetch_sequencer;

    localparam logic [7:0] S_REQ = 8'h80;
    localparam logic [7:0] S_IR  = 8'h40;
    localparam logic [7:0] S_INC = 8'h20;
    localparam logic [7:0] S_PCW = 8'h10;
    localparam logic [7:0] S_ACC = 8'h08;
    localparam logic [7:0] S_X   = 8'h04;
    localparam logic [7:0] S_Y   = 8'h02;
    localparam logic [7:0] S_FL  = 8'h01;
    localparam logic [7:0] S_FET = 8'hE0;
    localparam logic [7:0] S_OPA = 8'hA0;

    typedef struct {
        logic       run;
        logic       ack;
        logic [7:0] rdata;
        logic [7:0] strb;
        logic [1:0] stat;
        logic [7:0] op;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       run = 1'b0;
    logic       mem_req;
    logic       mem_ack = 1'b0;
    logic [7:0] mem_rdata = 8'h00;
    logic       ir_write, pc_inc, pc_write, acc_write, x_write, y_write, flags_write;
    logic [7:0] operand;
    logic       halted, bus_err;

    int vectors = 0;
    int miscompares = 0;
    vec_t tbl[$];

    fetch_sequencer #(.TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .run(run), .mem_req(mem_req), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .ir_write(ir_write), .pc_inc(pc_inc), .pc_write(pc_write),
        .acc_write(acc_write), .x_write(x_write), .y_write(y_write),
        .flags_write(flags_write), .operand(operand), .halted(halted), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic a, input logic [7:0] d,
                       input logic [7:0] s, input logic [1:0] st, input logic [7:0] o);
        vec_t v;
        v.run = r; v.ack = a; v.rdata = d; v.strb = s; v.stat = st; v.op = o;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [7:0] es,
                         input logic [1:0] est, input logic [7:0] eop);
        logic [7:0] as;
        logic [1:0] ast;
        as  = {mem_req, ir_write, pc_inc, pc_write, acc_write, x_write, y_write, flags_write};
        ast = {halted, bus_err};
        vectors++;
        if (as !== es || ast !== est || operand !== eop) begin
            miscompares++;
            $display("FAIL %s: got strb=%h stat=%b op=%h, want strb=%h stat=%b op=%h",
                     name, as, ast, operand, es, est, eop);
        end
    endtask

    task automatic cycle(input string name, input logic r, input logic a, input logic [7:0] d,
                         input logic [7:0] es, input logic [1:0] est, input logic [7:0] eop);
        @(posedge clk);
        #1;
        run = r; mem_ack = a; mem_rdata = d;
        @(negedge clk);
        check(name, es, est, eop);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; run = 1'b0; mem_ack = 1'b0; mem_rdata = 8'h00;
        @(negedge clk);
        check("reset_hold", 8'h00, 2'b00, 8'h00);
        reset = 1'b0;
    endtask

    initial begin
        // load 0x40 + 0x5A, jump 0x80 + 0x34, NOP, load-X with ack wait and run drop
        add(1,1,8'h40, S_FET, 2'b00, 8'h00);
        add(1,0,8'h00, 8'h00, 2'b00, 8'h00);
        add(1,1,8'h5A, S_OPA, 2'b00, 8'h00);
        add(1,0,8'h00, S_ACC, 2'b00, 8'h5A);
        add(1,1,8'h80, S_FET, 2'b00, 8'h5A);
        add(1,1,8'hEE, 8'h00, 2'b00, 8'h5A);
        add(1,1,8'h34, S_OPA, 2'b00, 8'h5A);
        add(1,0,8'h00, S_PCW, 2'b00, 8'h34);
        add(1,1,8'h00, S_FET, 2'b00, 8'h34);
        add(1,0,8'h00, 8'h00, 2'b00, 8'h34);
        add(1,1,8'h41, S_FET, 2'b00, 8'h34);
        add(1,0,8'h00, 8'h00, 2'b00, 8'h34);
        add(1,0,8'h00, S_REQ, 2'b00, 8'h34);
        add(0,1,8'h77, S_OPA, 2'b00, 8'h34);
        add(0,0,8'h00, S_X,   2'b00, 8'h77);
        add(0,1,8'h12, 8'h00, 2'b00, 8'h77);
        add(0,0,8'h00, 8'h00, 2'b00, 8'h77);
        add(1,1,8'hC3, S_FET, 2'b00, 8'h77);
        add(1,0,8'h00, 8'h00, 2'b00, 8'h77);
        add(1,1,8'h42, S_FET, 2'b00, 8'h77);
        add(1,0,8'h00, 8'h00, 2'b00, 8'h77);
        add(1,1,8'h99, S_OPA, 2'b00, 8'h77);
        add(1,0,8'h00, S_Y,   2'b00, 8'h99);
        add(1,1,8'h43, S_FET, 2'b00, 8'h99);
        add(1,0,8'h00, 8'h00, 2'b00, 8'h99);
        add(1,1,8'h01, S_OPA, 2'b00, 8'h99);
        add(1,0,8'h00, S_FL,  2'b00, 8'h01);
        add(1,1,8'hFF, S_FET, 2'b00, 8'h01);
        add(1,0,8'h00, 8'h00, 2'b00, 8'h01);
        add(1,1,8'h00, 8'h00, 2'b10, 8'h01);

        @(posedge clk);
        @(negedge clk);
        check("reset_state", 8'h00, 2'b00, 8'h00);
        reset = 1'b0;
        run   = 1'b1;
        #1;
        check("first_req_gate", 8'h00, 2'b00, 8'h00);

        for (int i = 0; i < tbl.size(); i++)
            cycle($sformatf("vec%0d", i), tbl[i].run, tbl[i].ack, tbl[i].rdata,
                  tbl[i].strb, tbl[i].stat, tbl[i].op);

        for (int i = 0; i < 20; i++)
            cycle("halt_hold", 1'b1, 1'(i % 2), 8'hA5, 8'h00, 2'b10, 8'h01);

        // operand never arrives: 15 stalled cycles then bus error
        do_reset();
        cycle("to_fetch", 1, 1, 8'h40, S_FET, 2'b00, 8'h00);
        cycle("to_decode", 1, 0, 8'h00, 8'h00, 2'b00, 8'h00);
        for (int i = 0; i < 15; i++)
            cycle("to_wait", 1, 0, 8'h00, S_REQ, 2'b00, 8'h00);
        cycle("to_buserr", 1, 0, 8'h00, 8'h00, 2'b11, 8'h00);
        cycle("to_ack_ignored", 1, 1, 8'h55, 8'h00, 2'b11, 8'h00);

        // asynchronous reset while an operand request is outstanding
        do_reset();
        cycle("rs_fetch", 1, 1, 8'h40, S_FET, 2'b00, 8'h00);
        cycle("rs_decode", 1, 0, 8'h00, 8'h00, 2'b00, 8'h00);
        cycle("rs_oper", 1, 1, 8'h11, S_OPA, 2'b00, 8'h00);
        cycle("rs_exec", 1, 0, 8'h00, S_ACC, 2'b00, 8'h11);
        cycle("rs_fetch2", 1, 1, 8'h80, S_FET, 2'b00, 8'h11);
        cycle("rs_decode2", 1, 0, 8'h00, 8'h00, 2'b00, 8'h11);
        cycle("rs_pending", 1, 0, 8'h00, S_REQ, 2'b00, 8'h11);
        #2;
        reset = 1'b1;
        #1;
        check("rs_async", 8'h00, 2'b00, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rs_release_gate", 8'h00, 2'b00, 8'h00);
        cycle("rs_restart", 1, 1, 8'h00, S_FET, 2'b00, 8'h00);
        cycle("rs_nop_decode", 1, 0, 8'h00, 8'h00, 2'b00, 8'h00);
        cycle("rs_refetch", 1, 0, 8'h00, S_REQ, 2'b00, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have port: clk  input  1  system clock, rising-edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: run  input  1  permits starting a new instruction fetch.
REQ-004 SHALL have port: mem_req  output  1  memory read request, level.
REQ-005 SHALL have port: mem_ack  input  1  memory read done; mem_rdata valid this cycle.
REQ-006 SHALL have port: mem_rdata  input  8  memory read data.
REQ-007 SHALL have ports: ir_write, pc_inc, pc_write, acc_write, x_write, y_write, flags_write  output  1 each  single-cycle register-file strobes.
REQ-008 SHALL have port: operand  output  8  last captured operand byte, register-file data_in source.
REQ-009 SHALL have ports: halted  output  1  HALT reached; bus_err  output  1  ack timeout.
REQ-010 SHALL have parameter: TIMEOUT, default 15, max cycles mem_req waits for mem_ack.

Function
REQ-011 SHALL implement states FETCH, DECODE, OPERAND, EXECUTE, HALT; reset state FETCH.
REQ-012 FETCH: mem_req=1 iff run=1; on mem_ack: capture opcode, pulse ir_write and pc_inc that cycle, go DECODE.
REQ-013 Opcode class = opcode[7:6]: 00 implied, 01 immediate-load, 10 jump, 11 special.
REQ-014 DECODE (1 cycle): opcode 0xFF -> HALT; class 01/10 -> OPERAND; class 00/11 (not 0xFF) -> FETCH, no strobes (NOP).
REQ-015 OPERAND: mem_req=1 regardless of run; on mem_ack: capture mem_rdata into operand, pulse pc_inc, go EXECUTE.
REQ-016 EXECUTE (1 cycle): class 01 pulses one strobe by opcode[1:0] (00 acc_write, 01 x_write, 10 y_write, 11 flags_write); class 10 pulses pc_write, no pc_inc; then FETCH.
REQ-017 Minimum instruction latency: implied 2 cycles, operand-bearing 4 cycles, zero-wait memory.
REQ-018 run deasserted mid-instruction SHALL NOT abort; sequencer completes and idles in FETCH with mem_req=0.
REQ-019 mem_ack when mem_req=0 SHALL be ignored.
REQ-020 Wait counter SHALL count mem_req-high cycles without ack; cleared on ack or state change; reaching TIMEOUT sets bus_err=1 and enters HALT.
REQ-021 HALT: all strobes and mem_req 0, halted=1; exit only by reset.
REQ-022 At most one of pc_write, acc_write, x_write, y_write, flags_write SHALL be high per cycle; pc_inc never with pc_write.

Reset
REQ-023 Reset SHALL force FETCH, all strobes 0, mem_req 0, operand 8'h00, halted 0, bus_err 0, wait counter 0, asynchronously, including mid-transaction.
REQ-024 First mem_req SHALL assert no earlier than the first clk edge after reset release.

Structure
REQ-025 State encoding, opcode-class constants, HALT opcode 8'hFF, destination-select codes SHALL live in shared package cpu_seq_pkg.
REQ-026 No sub-module; wait counter implemented inline.

Verification
REQ-027 run=1, zero-wait, opcode 0x40 then 0x5A -> ir_write, pc_inc, pc_inc, then acc_write with operand=0x5A, 4 cycles.
REQ-028 Opcode 0x80 operand 0x34 -> pc_write in EXECUTE with operand=0x34, exactly 2 pc_inc pulses.
REQ-029 Opcode 0x00 -> NOP, next FETCH mem_req 2 cycles after first ack.
REQ-030 No ack for 15 cycles in OPERAND -> bus_err=1, halted=1, mem_req=0.
REQ-031 Opcode 0xFF -> halted=1, mem_req stays 0 with run=1 for 20 cycles.
REQ-032 Reset asserted in OPERAND with mem_req=1 -> all outputs 0 immediately; after release fetch restarts.
